// File: rtl/accum_store.sv
// Store sequencer for the STO path: snapshots the accumulator and target address on start,
// then runs a SETUP / WRITE / HOLD bus cycle to data memory with wait states and a timeout abort.
module accum_store #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] accum,
    input  logic [ADDR_W-1:0] addr,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_oe,
    output logic              mem_wr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WRITE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Last WRITE cycle index before the strobe is abandoned; wait_cnt counts from 0.
    localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

    state_t            state;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        wait_cnt;
    logic              err_q;

    // Outputs are registered alongside the state, so each one reflects the state being entered.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            data_q   <= '0;
            addr_q   <= '0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
            bus_addr <= '0;
            bus_data <= '0;
            bus_oe   <= 1'b0;
            mem_wr   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        data_q   <= accum;
                        addr_q   <= addr;
                        bus_addr <= addr;
                        bus_data <= accum;
                        bus_oe   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    bus_addr <= addr_q;
                    bus_data <= data_q;
                    wait_cnt <= '0;
                    mem_wr   <= 1'b1;
                    state    <= WRITE;
                end
                WRITE: begin
                    // A ready on the final timeout cycle still counts as success.
                    if (mem_ready) begin
                        err_q  <= 1'b0;
                        mem_wr <= 1'b0;
                        state  <= HOLD;
                    end else if (wait_cnt == LAST_WAIT) begin
                        err_q  <= 1'b1;
                        mem_wr <= 1'b0;
                        state  <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                HOLD: begin
                    bus_oe   <= 1'b0;
                    bus_data <= '0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    err      <= err_q;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accum_store.sv
// Directed bench for accum_store: store timing, wait states, timeout, ignored restarts,
// asynchronous reset mid-write and back-to-back stores.
module tb_accum_store;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  accum = '0;
    logic [12:0] addr = '0;
    logic        mem_ready = 1'b0;
    logic [12:0] bus_addr;
    logic [7:0]  bus_data;
    logic        bus_oe, mem_wr, busy, done, err;

    int n_cmp = 0;
    int n_err = 0;
    int w_wr, w_oe, w_lat, w_err, w_bad, w_stray, n_done;

    accum_store #(.ADDR_W(13), .DATA_W(8), .TIMEOUT(15)) dut (
        .clk1(clk1), .rst(rst), .start(start), .accum(accum), .addr(addr),
        .mem_ready(mem_ready), .bus_addr(bus_addr), .bus_data(bus_data),
        .bus_oe(bus_oe), .mem_wr(mem_wr), .busy(busy), .done(done), .err(err)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic start_store(input logic [12:0] a, input logic [7:0] d);
        accum = d;
        addr  = a;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called in the SETUP cycle (cycle N+1). Follows the transaction up to the done cycle.
    // ready_at < 0: mem_ready tied high; 0: never ready; k: ready on the k-th WRITE cycle.
    task automatic watch(input int ready_at, input bit poke,
                         input logic [7:0] exp_d, input logic [12:0] exp_a);
        w_wr = 0; w_oe = 0; w_lat = -1; w_err = 0; w_bad = 0; w_stray = 0;
        for (int i = 0; i < 40; i++) begin
            if (mem_wr) w_wr++;
            if (bus_oe) begin
                w_oe++;
                if (bus_data !== exp_d || bus_addr !== exp_a) w_bad++;
            end else if (bus_data !== 8'h00) begin
                w_bad++;
            end
            if (done) begin
                w_lat = i + 1;
                w_err = int'(err);
                break;
            end
            if (err) w_stray++;
            mem_ready = (ready_at < 0) ? 1'b1 : (mem_wr && w_wr == ready_at);
            start = poke && mem_wr && (w_wr == 2);
            if (start) accum = 8'h3C;
            tick();
        end
        start = 1'b0;
        mem_ready = (ready_at < 0);
        $display("store addr=%h data=%h: wr_cycles=%0d oe_cycles=%0d done_cycle=N+%0d err=%0d",
                 exp_a, exp_d, w_wr, w_oe, w_lat, w_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_bus_oe", 32'(bus_oe), 0);
        chk("rst_mem_wr", 32'(mem_wr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_bus_addr", 32'(bus_addr), 0);
        chk("rst_bus_data", 32'(bus_data), 0);
        @(negedge clk1);
        rst = 1'b0;
        tick();
        tick();

        // 1: ready tied high
        mem_ready = 1'b1;
        start_store(13'h001F, 8'hA5);
        chk("t1_setup_oe", 32'(bus_oe), 1);
        chk("t1_setup_wr", 32'(mem_wr), 0);
        chk("t1_setup_busy", 32'(busy), 1);
        watch(-1, 1'b0, 8'hA5, 13'h001F);
        chk("t1_lat", w_lat, 4);
        chk("t1_wr", w_wr, 1);
        chk("t1_oe", w_oe, 3);
        chk("t1_err", w_err, 0);
        chk("t1_bus", w_bad, 0);
        chk("t1_addr_kept", 32'(bus_addr), 32'h001F);
        chk("t1_busy_done", 32'(busy), 0);
        tick();
        chk("t1_done_pulse", 32'(done), 0);

        // 2: ready on 4th WRITE cycle
        mem_ready = 1'b0;
        start_store(13'h001F, 8'hA5);
        watch(4, 1'b0, 8'hA5, 13'h001F);
        chk("t2_lat", w_lat, 7);
        chk("t2_wr", w_wr, 4);
        chk("t2_oe", w_oe, 6);
        chk("t2_err", w_err, 0);
        chk("t2_bus", w_bad, 0);

        // 3: timeout abort, then ready on the last allowed cycle
        tick();
        start_store(13'h0ABC, 8'h5A);
        watch(0, 1'b0, 8'h5A, 13'h0ABC);
        chk("t3_lat", w_lat, 18);
        chk("t3_wr", w_wr, 15);
        chk("t3_oe", w_oe, 17);
        chk("t3_err", w_err, 1);
        chk("t3_err_stray", w_stray, 0);
        tick();
        chk("t3_err_clear", 32'(err), 0);
        start_store(13'h0ABC, 8'h5A);
        watch(15, 1'b0, 8'h5A, 13'h0ABC);
        chk("t3b_wr", w_wr, 15);
        chk("t3b_lat", w_lat, 18);
        chk("t3b_err", w_err, 0);

        // 4: restart attempt and accum change during WRITE are ignored
        tick();
        start_store(13'h1ABC, 8'hA5);
        watch(3, 1'b1, 8'hA5, 13'h1ABC);
        chk("t4_lat", w_lat, 6);
        chk("t4_wr", w_wr, 3);
        chk("t4_bus", w_bad, 0);
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy) n_done++;
        end
        chk("t4_no_second", n_done, 0);

        // 5: async reset during WRITE
        mem_ready = 1'b0;
        start_store(13'h001F, 8'hA5);
        tick();
        chk("t5_in_write", 32'(mem_wr), 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_wr", 32'(mem_wr), 0);
        chk("t5_rst_oe", 32'(bus_oe), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        @(negedge clk1);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) n_done++;
        end
        chk("t5_no_done", n_done, 0);
        mem_ready = 1'b1;
        start_store(13'h001F, 8'hA5);
        watch(-1, 1'b0, 8'hA5, 13'h001F);
        chk("t5_after_lat", w_lat, 4);
        chk("t5_after_err", w_err, 0);

        // 6: start accepted in the done cycle
        chk("t6_in_done", 32'(done), 1);
        start_store(13'h0042, 8'h77);
        chk("t6_setup_oe", 32'(bus_oe), 1);
        chk("t6_setup_busy", 32'(busy), 1);
        chk("t6_setup_data", 32'(bus_data), 32'h77);
        watch(-1, 1'b0, 8'h77, 13'h0042);
        chk("t6_lat", w_lat, 4);
        chk("t6_bus", w_bad, 0);
        chk("t6_err", w_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
